// File: rtl/exu_bjp_resolve_pkg.sv
// Shared widths and FSM state encoding for the branch/jump resolution slice.
package exu_bjp_resolve_pkg;
  localparam int E203_PC_SIZE = 32;
  localparam int E203_XLEN    = 32;
  localparam int CNT_W        = 32;

  typedef enum logic {
    IDLE       = 1'b0,
    FLUSH_WAIT = 1'b1
  } bjp_state_e;
endpackage

// File: rtl/exu_bjp_resolve_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
import exu_bjp_resolve_pkg::*;

module exu_sat_cnt #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (inc && (cnt_reg != {W{1'b1}}))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/exu_bjp_resolve.sv
// Resolves branch/jump outcomes against the front-end prediction, raises a
// registered flush with next-PC adder operands, and counts branches/mispredicts.
import exu_bjp_resolve_pkg::*;

module exu_bjp_resolve #(
  parameter int PC_SIZE = E203_PC_SIZE,
  parameter int XLEN    = E203_XLEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_bxx,
  input  logic               cmt_i_prdt_taken,
  input  logic               cmt_i_rslv_taken,
  input  logic               cmt_i_rv32,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [XLEN-1:0]    cmt_i_imm,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic [PC_SIZE-1:0] flush_add_op1,
  output logic [PC_SIZE-1:0] flush_add_op2,
  output logic               nonflush_cmt_ena,
  input  logic               perf_clr,
  output logic [31:0]        bjp_cnt,
  output logic [31:0]        mis_cnt
);

  bjp_state_e         state_reg, state_next;
  logic [PC_SIZE-1:0] op1_reg, op2_reg;
  logic [PC_SIZE-1:0] mis_op2;
  logic               accept;
  logic               mis;

  assign accept = cmt_i_valid & cmt_i_ready;
  // jal/jalr targets are exact in the front end, so only bxx can mispredict
  assign mis    = cmt_i_bjp & cmt_i_bxx & (cmt_i_prdt_taken ^ cmt_i_rslv_taken);

  // Predicted taken but fell through: restart at the sequential PC
  assign mis_op2 = cmt_i_prdt_taken ? (cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2))
                                    : cmt_i_imm[PC_SIZE-1:0];

  always_comb begin
    state_next       = state_reg;
    cmt_i_ready      = 1'b0;
    nonflush_cmt_ena = 1'b0;
    case (state_reg)
      IDLE: begin
        cmt_i_ready      = 1'b1;
        nonflush_cmt_ena = cmt_i_valid & cmt_i_bjp & ~mis;
        if (cmt_i_valid && mis)
          state_next = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (flush_ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op1_reg   <= '0;
      op2_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && mis) begin
        op1_reg <= cmt_i_pc;
        op2_reg <= mis_op2;
      end
    end
  end

  assign flush_req     = (state_reg == FLUSH_WAIT);
  assign flush_add_op1 = op1_reg;
  assign flush_add_op2 = op2_reg;

  // Index 0 counts retired branches/jumps, index 1 counts mispredicts
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = accept & cmt_i_bjp;
  assign cnt_inc[1] = accept & mis;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    exu_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[gi]),
      .clr   (perf_clr),
      .cnt   (cnt_val[gi])
    );
  end

  assign bjp_cnt = cnt_val[0];
  assign mis_cnt = cnt_val[1];

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Directed bench: expected values queued at stimulus time, popped at sample time.
module tb_exu_bjp_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmt_i_valid, cmt_i_ready, cmt_i_bjp, cmt_i_bxx;
  logic        cmt_i_prdt_taken, cmt_i_rslv_taken, cmt_i_rv32;
  logic [31:0] cmt_i_pc, cmt_i_imm;
  logic        flush_req, flush_ack;
  logic [31:0] flush_add_op1, flush_add_op2;
  logic        nonflush_cmt_ena, perf_clr;
  logic [31:0] bjp_cnt, mis_cnt;

  logic        sc_inc, sc_clr;
  logic [3:0]  sc_cnt;

  always #5 clk = ~clk;

  exu_bjp_resolve #(.PC_SIZE(32), .XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmt_i_valid      (cmt_i_valid),
    .cmt_i_ready      (cmt_i_ready),
    .cmt_i_bjp        (cmt_i_bjp),
    .cmt_i_bxx        (cmt_i_bxx),
    .cmt_i_prdt_taken (cmt_i_prdt_taken),
    .cmt_i_rslv_taken (cmt_i_rslv_taken),
    .cmt_i_rv32       (cmt_i_rv32),
    .cmt_i_pc         (cmt_i_pc),
    .cmt_i_imm        (cmt_i_imm),
    .flush_req        (flush_req),
    .flush_ack        (flush_ack),
    .flush_add_op1    (flush_add_op1),
    .flush_add_op2    (flush_add_op2),
    .nonflush_cmt_ena (nonflush_cmt_ena),
    .perf_clr         (perf_clr),
    .bjp_cnt          (bjp_cnt),
    .mis_cnt          (mis_cnt)
  );

  // Narrow instance so saturation is reachable in a few cycles
  exu_sat_cnt #(.W(4)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .cnt   (sc_cnt)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL scoreboard_empty observed=%h required=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
      $display("check %s observed=%h", e.tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic bjp, input logic bxx,
                       input logic prdt, input logic rslv, input logic rv32,
                       input logic [31:0] pc, input logic [31:0] imm);
    cmt_i_valid      = v;
    cmt_i_bjp        = bjp;
    cmt_i_bxx        = bxx;
    cmt_i_prdt_taken = prdt;
    cmt_i_rslv_taken = rslv;
    cmt_i_rv32       = rv32;
    cmt_i_pc         = pc;
    cmt_i_imm        = imm;
    #1;
  endtask

  task automatic idle_in;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_flush(input string t, input logic [31:0] op1, input logic [31:0] op2,
                             input logic [31:0] bc, input logic [31:0] mc);
    push({t, "_req"}, 32'd1);   pop_check({31'd0, flush_req});
    push({t, "_op1"}, op1);     pop_check(flush_add_op1);
    push({t, "_op2"}, op2);     pop_check(flush_add_op2);
    push({t, "_bjp"}, bc);      pop_check(bjp_cnt);
    push({t, "_mis"}, mc);      pop_check(mis_cnt);
    push({t, "_rdy"}, 32'd0);   pop_check({31'd0, cmt_i_ready});
  endtask

  task automatic ack_flush;
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_ack = 1'b0; perf_clr = 1'b0;
    sc_inc = 1'b0; sc_clr = 1'b0;
    idle_in();
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    push("rst_req", 32'd0); pop_check({31'd0, flush_req});
    push("rst_op1", 32'd0); pop_check(flush_add_op1);
    push("rst_op2", 32'd0); pop_check(flush_add_op2);
    push("rst_bjp", 32'd0); pop_check(bjp_cnt);
    push("rst_mis", 32'd0); pop_check(mis_cnt);
    push("rst_rdy", 32'd1); pop_check({31'd0, cmt_i_ready});

    // Predicted taken, resolved not taken, rv32
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 32'h40);
    push("t1_nfl", 32'd0); pop_check({31'd0, nonflush_cmt_ena});
    tick(); idle_in();
    check_flush("t1", 32'h8000_0100, 32'h4, 32'd1, 32'd1);
    ack_flush();
    push("t1_back_req", 32'd0); pop_check({31'd0, flush_req});
    push("t1_back_rdy", 32'd1); pop_check({31'd0, cmt_i_ready});

    // Predicted not taken, resolved taken, rv16 -> offset
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h40);
    tick(); idle_in();
    check_flush("t2", 32'h0000_1000, 32'h40, 32'd2, 32'd2);
    ack_flush();

    // Predicted taken, resolved not taken, rv16 -> +2
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2002, 32'h40);
    tick(); idle_in();
    check_flush("t3", 32'h0000_2002, 32'h2, 32'd3, 32'd3);
    ack_flush();

    // jal: never a mispredict, retires with nonflush_cmt_ena
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h80);
    push("jal_nfl", 32'd1); pop_check({31'd0, nonflush_cmt_ena});
    tick(); idle_in();
    push("jal_req", 32'd0); pop_check({31'd0, flush_req});
    push("jal_bjp", 32'd4); pop_check(bjp_cnt);
    push("jal_mis", 32'd3); pop_check(mis_cnt);

    // Non-branch instruction has no effect
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3004, 32'h0);
    push("alu_nfl", 32'd0); pop_check({31'd0, nonflush_cmt_ena});
    tick(); idle_in();
    push("alu_req", 32'd0); pop_check({31'd0, flush_req});
    push("alu_bjp", 32'd4); pop_check(bjp_cnt);

    // Stall: flush_ack withheld while new mispredict data is offered
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h100);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h8);
    for (int i = 0; i < 5; i++) begin
      check_flush("stall", 32'h0000_5000, 32'h100, 32'd5, 32'd4);
      push("stall_nfl", 32'd0); pop_check({31'd0, nonflush_cmt_ena});
      tick();
    end
    ack_flush();
    push("post_ack_rdy", 32'd1); pop_check({31'd0, cmt_i_ready});
    tick(); idle_in();
    check_flush("post_ack", 32'h0000_4000, 32'h4, 32'd6, 32'd5);

    // Reset while a flush is pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    push("rst2_req", 32'd0); pop_check({31'd0, flush_req});
    push("rst2_op1", 32'd0); pop_check(flush_add_op1);
    push("rst2_op2", 32'd0); pop_check(flush_add_op2);
    push("rst2_bjp", 32'd0); pop_check(bjp_cnt);
    push("rst2_mis", 32'd0); pop_check(mis_cnt);
    push("rst2_rdy", 32'd1); pop_check({31'd0, cmt_i_ready});

    // perf_clr beats a same-cycle mispredict increment
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 32'h10);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_6004, 32'h20);
    perf_clr = 1'b1;
    tick(); idle_in();
    perf_clr = 1'b0;
    check_flush("clr", 32'h0000_6004, 32'h20, 32'd0, 32'd0);
    ack_flush();

    // Saturation on the narrow counter, then clear over increment
    sc_inc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    push("sat_14", 32'd14); pop_check({28'd0, sc_cnt});
    tick();
    push("sat_15", 32'd15); pop_check({28'd0, sc_cnt});
    for (int i = 0; i < 3; i++) tick();
    push("sat_hold", 32'd15); pop_check({28'd0, sc_cnt});
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0; sc_inc = 1'b0;
    push("sat_clr", 32'd0); pop_check({28'd0, sc_cnt});

    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
